// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 32-bit signed/unsigned radix-2 restoring divider
//
// Purpose:
//   Responder on the EX-stage div_* handshake. A request is latched from FREE,
//   worked on for 32 cycles (one quotient bit per cycle), and the corrected
//   {remainder, quotient} is then held with ready_o until EX drops start_i.
//   Division by zero completes early with a zero result and never traps.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   signed_div_i  1 = DIV (signed), 0 = DIVU; sampled on acceptance only
//   opdata1_i     dividend; sampled on acceptance only
//   opdata2_i     divisor; sampled on acceptance only
//   start_i       request, held high by EX until it sees ready_o
//   annul_i       abort the division in flight (only with DIV_ANNUL_EN)
//   result_o      {remainder[63:32], quotient[31:0]} -> HI, LO
//   ready_o       result_o is valid
//
// Configuration:
//   DIV_ANNUL_EN  when defined, annul_i aborts BY_ZERO/ON and blocks acceptance
//                 in FREE; when undefined annul_i is ignored.

module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  cnt;        // iteration index 0..31
  logic [64:0] work;       // {partial remainder[64:32], quotient[31:0]}
  logic [31:0] divisor;    // |divisor|
  logic        neg_quot;   // quotient needs negating at the end
  logic        neg_rem;    // remainder needs negating at the end

  // Abort request, compiled away entirely when the feature is disabled.
  logic abort;
`ifdef DIV_ANNUL_EN
  assign abort = annul_i;
`else
  logic unused_annul;
  assign abort        = 1'b0;
  assign unused_annul = annul_i;
`endif

  // Operand magnitudes for the unsigned core.
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;

  always_comb begin
    dividend_mag = opdata1_i;
    divisor_mag  = opdata2_i;
    if (signed_div_i && opdata1_i[31]) dividend_mag = ~opdata1_i + 32'd1;
    if (signed_div_i && opdata2_i[31]) divisor_mag  = ~opdata2_i + 32'd1;
  end

  // One restoring step: shift left, trial-subtract, keep the difference if
  // it did not borrow. The partial remainder is always below the divisor, so
  // the shifted value fits the 33-bit upper field.
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [64:0] work_next;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    shifted   = {work[63:0], 1'b0};
    diff      = shifted[64:32] - {1'b0, divisor};
    work_next = shifted;
    if (!diff[32]) begin
      work_next = {diff, shifted[31:1], 1'b1};
    end
    quot_fix = neg_quot ? (~work_next[31:0] + 32'd1) : work_next[31:0];
    rem_fix  = neg_rem  ? (~work_next[63:32] + 32'd1) : work_next[63:32];
  end

  // work[64] is always zero after a step; only [63:0] feeds the next shift.
  logic unused_work_msb;
  assign unused_work_msb = work[64];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 5'd0;
      work     <= 65'd0;
      divisor  <= 32'd0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i && !abort) begin
            cnt      <= 5'd0;
            work     <= {33'd0, dividend_mag};
            divisor  <= divisor_mag;
            neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem  <= signed_div_i & opdata1_i[31];
            state    <= (opdata2_i == 32'd0) ? BY_ZERO : ON;
          end
        end

        BY_ZERO: begin
          if (abort) begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else begin
            result_o <= 64'd0;
            ready_o  <= 1'b1;
            state    <= END;
          end
        end

        ON: begin
          if (abort) begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else begin
            work <= work_next;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result_o <= {rem_fix, quot_fix};
              ready_o  <= 1'b1;
              state    <= END;
            end
          end
        end

        END: begin
          // Result is held for as long as EX keeps the request up.
          if (!start_i) begin
            result_o <= 64'd0;
            ready_o  <= 1'b0;
            state    <= FREE;
          end
        end

        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic model

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sampling happens at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: plain 64-bit arithmetic, truncating division.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one request from FREE (called at a falling edge), check latency,
  // result, hold stability and release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int          lat;
    int          exp_lat;
    exp     = model(sgn, a, b);
    exp_lat = (b == 32'd0) ? 2 : 33;
    signed_div = sgn;
    op1   = a;
    op2   = b;
    start = 1'b1;
    lat   = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      step();
      // Operands are only sampled on acceptance; scramble them afterwards.
      signed_div = 1'($urandom);
      op1 = $urandom;
      op2 = $urandom;
      if (ready) lat = k;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp);
    for (int h = 0; h < hold; h++) begin
      step();
      op1 = $urandom;
      op2 = $urandom;
      check({tag, " hold ready"}, {63'd0, ready}, 64'd1);
      check({tag, " hold result"}, result, exp);
    end
    start = 1'b0;
    step();
    check({tag, " release ready"}, {63'd0, ready}, 64'd0);
    check({tag, " release result"}, result, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] cap;
    int          lat;

    rst = 1'b1;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    start = 1'b0;
    annul = 1'b0;
    step();
    step();
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;
    step();

    run_div("divu 100/7",       1'b0, 32'd100,       32'd7,         0);
    run_div("div -8/3",         1'b1, 32'hFFFFFFF8,  32'd3,         0);
    run_div("div 7/-2",         1'b1, 32'd7,         32'hFFFFFFFE,  0);
    run_div("div by zero",      1'b1, 32'h12345678,  32'd0,         0);
    run_div("div min/-1",       1'b1, 32'h80000000,  32'hFFFFFFFF,  0);
    run_div("divu max/1",       1'b0, 32'hFFFFFFFF,  32'd1,         0);
    run_div("hold",             1'b1, 32'hDEADBEEF,  32'd12345,     5);
    run_div("after hold",       1'b0, 32'hDEADBEEF,  32'd12345,     0);
    run_div("divu small/large", 1'b0, 32'd5,         32'hFFFFFFF0,  0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 20));
        1: rb = 32'd0;
        2: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_div("random", rs, ra, rb, int'($urandom_range(0, 2)));
    end

    // Abort at T+10, request dropped at the same time.
    signed_div = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    for (int k = 1; k <= 10; k++) step();
    annul = 1'b1;
    start = 1'b0;
    step();
    annul = 1'b0;
    check("annul T+11 ready", {63'd0, ready}, 64'd0);
    lat = 0;
    cap = 64'd0;
    for (int k = 12; k <= 45; k++) begin
      step();
      if (ready && lat == 0) begin
        lat = k;
        cap = result;
      end
    end
`ifdef DIV_ANNUL_EN
    check("annul no ready", 64'(lat), 64'd0);
`else
    check("annul ignored latency", 64'(lat), 64'd33);
    check("annul ignored result", cap, {32'd1, 32'd333});
`endif

    // Reset mid-division at T+5.
    signed_div = 1'b1;
    op1 = 32'hFFFF0000;
    op2 = 32'd7;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    rst = 1'b1;
    start = 1'b0;
    step();
    check("midrst ready", {63'd0, ready}, 64'd0);
    check("midrst result", result, 64'd0);
    rst = 1'b0;
    run_div("after midrst", 1'b1, 32'hFFFF0000, 32'd7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
